alu_uart_ctrl: RTL and testbench

Frame controller between the UART receiver/transmitter and the combinational ALU. It collects three received bytes (operand A, operand B, opcode) and holds them on the ALU inputs. It then captures the ALU result one cycle later and hands it to the UART transmitter with a start/done handshake. It is the only sequential stage between the serial link and the ALU.

---
 rtl/alu_uart_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_uart_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - UART-to-ALU frame controller (A, B, opcode in; result out)
// Optional inter-byte timeout is built when ALU_CTRL_TIMEOUT_EN is defined.
module alu_uart_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t state;
    logic   timed_out;
    logic   collecting;

    assign collecting = (state == WAIT_B) || (state == WAIT_OP);

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign timed_out = collecting && !i_rx_valid && (cnt == TERM);

    // Counter idles at zero outside WAIT_B/WAIT_OP; an accepted byte wins over the terminal count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timed_out;
            if (collecting && !i_rx_valid && !timed_out) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timed_out = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_valid) begin
                        o_alu_a <= i_rx_data;
                        state   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_valid) begin
                        o_alu_b <= i_rx_data;
                        state   <= WAIT_OP;
                    end else if (timed_out) begin
                        state <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_valid) begin
                        o_alu_op <= i_rx_data[NB_OP-1:0];
                        o_busy   <= 1'b1;
                        state    <= EXEC;
                    end else if (timed_out) begin
                        state <= WAIT_A;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle; result is settled here.
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb/tb_alu_uart_ctrl.sv - directed self-checking bench for alu_uart_ctrl
module tb_alu_uart_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    alu_uart_ctrl #(
        .NB_DATA       (8),
        .NB_OP         (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_tx_done   (tx_done),
        .i_alu_result(alu_result),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU attached to the controller outputs.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h03:   alu_result = $unsigned($signed(alu_a) >>> alu_b);
            6'h02:   alu_result = alu_a >> alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was sampled.
    task automatic rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] res);
        rx(a);
        rx(b);
        rx(op);
        check({tag, " op"}, alu_op, op[5:0]);
        check({tag, " busy_exec"}, busy, 1);
        check({tag, " start_exec"}, tx_start, 0);
        @(negedge clk);
        check({tag, " start_send"}, tx_start, 1);
        check({tag, " data"}, tx_data, res);
        @(negedge clk);
        check({tag, " start_wait"}, tx_start, 0);
        check({tag, " busy_wait"}, busy, 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({tag, " busy_idle"}, busy, 0);
        check({tag, " data_hold"}, tx_data, res);
    endtask

    initial begin
        int pulses;
        int pulse_at;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst a", alu_a, 0);
        check("rst b", alu_b, 0);
        check("rst op", alu_op, 0);
        check("rst txdata", tx_data, 0);
        check("rst start", tx_start, 0);
        check("rst busy", busy, 0);
        check("rst timeout", timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        check("add a_hold", alu_a, 8'h05);
        check("add b_hold", alu_b, 8'h03);
        frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
        frame("sra", 8'h80, 8'h01, 8'h03, 8'hC0);
        frame("srl_mask", 8'h80, 8'h01, 8'hC2, 8'h40);

        // Byte and stray tx_done while busy must be ignored.
        rx(8'h11);
        rx(8'h01);
        rx(8'h20);
        @(negedge clk);
        @(negedge clk);
        check("drop data", tx_data, 8'h12);
        rx(8'h55);
        check("drop a", alu_a, 8'h11);
        check("drop busy", busy, 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("drop idle", busy, 0);
        frame("or", 8'h0F, 8'hF0, 8'h25, 8'hFF);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray done", busy, 0);

        // Asynchronous reset mid-frame.
        rx(8'hAA);
        rx(8'h77);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst a", alu_a, 0);
        check("mid rst b", alu_b, 0);
        check("mid rst op", alu_op, 0);
        check("mid rst txdata", tx_data, 0);
        check("mid rst busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame("post rst", 8'h01, 8'h01, 8'h20, 8'h02);

        // Send only operand A then idle.
        rx(8'h09);
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
        end
`ifdef ALU_CTRL_TIMEOUT_EN
        check("to pulses", pulses, 1);
        check("to cycle", pulse_at, 16);
        check("to a_kept", alu_a, 8'h09);
        frame("after to", 8'h06, 8'h02, 8'h22, 8'h04);
`else
        check("no to pulses", pulses, 0);
        check("no to busy", busy, 0);
        // Still waiting for operand B: next two bytes complete the frame.
        rx(8'h02);
        rx(8'h20);
        check("no to op", alu_op, 6'h20);
        check("no to busy_exec", busy, 1);
        @(negedge clk);
        check("no to data", tx_data, 8'h0B);
        check("no to start", tx_start, 1);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("no to idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
